morse_sequencer: RTL

//  Accepts ASCII characters over a valid/ready handshake and looks each one up in morse_table.
//  It then keys the returned code out on one on/off line with standard Morse unit timing.

---
 rtl/morse_sequencer.sv | 80 ++++++++
 1 files changed

// File: rtl/morse_sequencer.sv
// morse_sequencer: looks up ASCII characters in morse_table and keys them out with Morse unit timing
module morse_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int UNIT_CYCLES = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [ADDR_WIDTH-1:0] table_addr,
  input  logic [DATA_WIDTH-1:0] table_data,
  output logic                  morse_out,
  output logic                  busy,
  output logic                  char_done,
  output logic                  char_err
);
  localparam int CW = $clog2(UNIT_CYCLES);
  localparam int SW = $clog2(DATA_WIDTH / 2) + 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, LATCH, DECODE, MARK, SYM_GAP, CHAR_GAP, WORD_GAP} state_t;
  state_t state, next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [SW-1:0] sym_cnt, sym_nxt;
  logic [CW-1:0] cyc_cnt;
  logic [2:0] unit_cnt, target;
  logic dash, tick, done, timed, accept, last_sym;
  assign char_ready = state == IDLE;
  assign busy = !char_ready;
  assign morse_out = state == MARK;
  assign accept = char_valid && char_ready;
  assign sym_nxt = sym_cnt + SW'(1);
  assign tick = cyc_cnt == CW'(UNIT_CYCLES - 1);
  assign timed = state inside {MARK, SYM_GAP, CHAR_GAP, WORD_GAP};
  assign target = state == MARK ? (dash ? 3'd3 : 3'd1) :
                  state == SYM_GAP ? 3'd1 : state == CHAR_GAP ? 3'd3 : 3'd7;
  assign done = tick && unit_cnt == target - 3'd1;
  assign last_sym = !shreg[DATA_WIDTH-3] || sym_nxt == SW'(DATA_WIDTH / 2);
  // next-state decode plus the one-cycle done/error pulses
  always_comb begin
    next = state;
    char_done = 1'b0;
    char_err = 1'b0;
    case (state)
      IDLE:     if (accept) next = char_in == ADDR_WIDTH'('h20) ? WORD_GAP : LOOKUP;
      LOOKUP:   next = LATCH;
      LATCH:    begin next = |table_data ? DECODE : IDLE; char_err = ~|table_data; end
      DECODE:   next = shreg[DATA_WIDTH-1] ? MARK : CHAR_GAP;
      MARK:     if (done) next = last_sym ? CHAR_GAP : SYM_GAP;
      SYM_GAP:  if (done) next = DECODE;
      default:  if (done) begin next = IDLE; char_done = 1'b1; end
    endcase
  end
  // state register, lookup address and symbol shift register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      table_addr <= '0;
      shreg <= '0;
      sym_cnt <= '0;
      dash <= 1'b0;
    end else begin
      state <= next;
      if (next == LOOKUP) table_addr <= char_in;
      if (state == LATCH) begin shreg <= table_data; sym_cnt <= '0; end
      if (state == DECODE) dash <= shreg[DATA_WIDTH-2];
      if (state == MARK && done) begin shreg <= shreg << 2; sym_cnt <= sym_nxt; end
    end
  end
  // unit timer, cleared on every state change so nothing carries between states
  always_ff @(posedge clk) begin
    if (!rst_n || next != state || !timed) begin
      cyc_cnt <= '0;
      unit_cnt <= '0;
    end else begin
      cyc_cnt <= tick ? '0 : cyc_cnt + CW'(1);
      if (tick) unit_cnt <= unit_cnt + 3'd1;
    end
  end
endmodule
